// File: rtl/tmul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tmul_seq_ctrl : digit-serial WIDTH x WIDTH multiply on a shared DIGIT array
// Revision      : 1.0
// ============================================================================
module tmul_seq_ctrl #(
    parameter int WIDTH     = 16,
    parameter int DIGIT     = 4,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iValid,
    output logic                 oReady,
    input  logic [WIDTH-1:0]     iA,
    input  logic [WIDTH-1:0]     iB,
    output logic                 oValid,
    input  logic                 iReady,
    output logic [2*WIDTH-1:0]   oP,
    output logic [DIGIT-1:0]     oMulA,
    output logic [DIGIT-1:0]     oMulB,
    input  logic [2*DIGIT-1:0]   iMulP,
    output logic                 oBusy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [IW-1:0]     i_q, j_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [PW-1:0]     acc_q, acc_d;
    logic              skip_q, valid_q, ready_q, busy_q;
    logic              mul_active;
    logic [DIGIT-1:0]  a_dig [N];
    logic [DIGIT-1:0]  b_dig [N];

    generate
        for (genvar g = 0; g < N; g++) begin : g_dig
            assign a_dig[g] = a_q[g*DIGIT +: DIGIT];
            assign b_dig[g] = b_q[g*DIGIT +: DIGIT];
        end
    endgenerate

    // A zero-operand bypass spends its single MUL cycle with the array idle.
    assign mul_active = (state_q == S_MUL) && !skip_q;

    always_comb begin
        oMulA = '0;
        oMulB = '0;
        if (mul_active) begin
            oMulA = a_dig[i_q];
            oMulB = b_dig[j_q];
        end
        acc_d = acc_q + (PW'(iMulP) << (DIGIT * (int'(i_q) + int'(j_q))));
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            skip_q  <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (iValid) begin
                        a_q     <= iA;
                        b_q     <= iB;
                        acc_q   <= '0;
                        i_q     <= '0;
                        j_q     <= '0;
                        skip_q  <= SKIP_ZERO && ((iA == '0) || (iB == '0));
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (skip_q) begin
                        skip_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        acc_q <= acc_d;
                        if (j_q == LAST) begin
                            j_q <= '0;
                            if (i_q == LAST) begin
                                i_q     <= '0;
                                valid_q <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                i_q <= i_q + IW'(1);
                            end
                        end else begin
                            j_q <= j_q + IW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (iReady) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign oP     = acc_q;
    assign oValid = valid_q;
    assign oReady = ready_q;
    assign oBusy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_tmul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_tmul_seq_ctrl : scoreboard bench for tmul_seq_ctrl (SKIP_ZERO=1 and =0)
// Revision         : 1.0
// ============================================================================
module tb_tmul_seq_ctrl;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        iValid = 1'b0, iReady = 1'b0;
    logic [15:0] iA = '0, iB = '0;
    logic        oReady, oValid, oBusy;
    logic [31:0] oP;
    logic [3:0]  oMulA, oMulB;
    logic [7:0]  iMulP;

    logic        iValid0 = 1'b0, iReady0 = 1'b1;
    logic [15:0] iA0 = '0, iB0 = '0;
    logic        oReady0, oValid0, oBusy0;
    logic [31:0] oP0;
    logic [3:0]  oMulA0, oMulB0;
    logic [7:0]  iMulP0;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] sb[$];

    always #5 Clock = ~Clock;

    // Behavioural 4x4 array multiplier model
    assign iMulP  = {4'b0, oMulA}  * {4'b0, oMulB};
    assign iMulP0 = {4'b0, oMulA0} * {4'b0, oMulB0};

    tmul_seq_ctrl #(.WIDTH(16), .DIGIT(4), .SKIP_ZERO(1'b1)) dut (
        .Clock(Clock), .Reset(Reset), .iValid(iValid), .oReady(oReady),
        .iA(iA), .iB(iB), .oValid(oValid), .iReady(iReady), .oP(oP),
        .oMulA(oMulA), .oMulB(oMulB), .iMulP(iMulP), .oBusy(oBusy)
    );

    tmul_seq_ctrl #(.WIDTH(16), .DIGIT(4), .SKIP_ZERO(1'b0)) dut0 (
        .Clock(Clock), .Reset(Reset), .iValid(iValid0), .oReady(oReady0),
        .iA(iA0), .iB(iB0), .oValid(oValid0), .iReady(iReady0), .oP(oP0),
        .oMulA(oMulA0), .oMulB(oMulB0), .iMulP(iMulP0), .oBusy(oBusy0)
    );

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        compared++;
        if (oReady !== 1'b1) begin
            mismatched++;
            $display("FAIL send_ready: oReady=%b required 1", oReady);
        end
        iA = a; iB = b; iValid = 1'b1;
        @(posedge Clock);
        sb.push_back({16'b0, a} * {16'b0, b});
        #1 iValid = 1'b0;
    endtask

    // Waits for the result, checks digit stream, latency, product, backpressure
    task automatic collect(input logic [15:0] a, input logic [15:0] b,
                           input int exp_lat, input int hold);
        logic [31:0] exp_p;
        logic [15:0] ta, tb;
        logic [3:0]  da, db;
        int n;
        exp_p = sb.pop_front();
        n = 0;
        do begin
            @(negedge Clock);
            n++;
            if (!oValid && n <= exp_lat) begin
                da = 4'h0; db = 4'h0;
                if (exp_lat == 16) begin
                    ta = a >> (4 * ((n - 1) / 4));
                    tb = b >> (4 * ((n - 1) % 4));
                    da = ta[3:0]; db = tb[3:0];
                end
                compared++;
                if ({oMulA, oMulB} !== {da, db}) begin
                    mismatched++;
                    $display("FAIL digits cyc%0d: oMulA/oMulB=%h/%h required %h/%h",
                             n - 1, oMulA, oMulB, da, db);
                end
            end
        end while (!oValid && n < 40);
        compared++;
        if (n != exp_lat + 1) begin
            mismatched++;
            $display("FAIL latency: oValid after %0d edges required %0d (oValid=%b)",
                     n - 1, exp_lat, oValid);
        end
        compared++;
        if (oP !== exp_p) begin
            mismatched++;
            $display("FAIL product %h*%h: oP=%h required %h", a, b, oP, exp_p);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge Clock);
            compared++;
            if (oValid !== 1'b1 || oP !== exp_p || oReady !== 1'b0 || oBusy !== 1'b1) begin
                mismatched++;
                $display("FAIL hold%0d: oValid=%b oP=%h oReady=%b oBusy=%b required 1 %h 0 1",
                         h, oValid, oP, oReady, oBusy, exp_p);
            end
        end
        iReady = 1'b1;
        @(negedge Clock);
        iReady = 1'b0;
        compared++;
        if (oValid !== 1'b0 || oReady !== 1'b1 || oBusy !== 1'b0) begin
            mismatched++;
            $display("FAIL release: oValid=%b oReady=%b oBusy=%b required 0 1 0",
                     oValid, oReady, oBusy);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (3) @(negedge Clock);
        compared++;
        if (oValid !== 1'b0 || oReady !== 1'b1 || oP !== 32'h0 ||
            oMulA !== 4'h0 || oMulB !== 4'h0 || oBusy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset: V=%b R=%b P=%h A=%h B=%h busy=%b required 0 1 0 0 0 0",
                     oValid, oReady, oP, oMulA, oMulB, oBusy);
        end
        Reset = 1'b1;
        @(negedge Clock);
    endtask

    task automatic test_small();
        send(16'h0003, 16'h0005);
        collect(16'h0003, 16'h0005, 16, 0);
    endtask

    task automatic test_patterns();
        send(16'hFFFF, 16'hFFFF);
        collect(16'hFFFF, 16'hFFFF, 16, 0);
        send(16'h1234, 16'h00AB);
        collect(16'h1234, 16'h00AB, 16, 0);
        send(16'h8001, 16'h7FFE);
        collect(16'h8001, 16'h7FFE, 16, 0);
    endtask

    task automatic test_zero_bypass();
        send(16'h0000, 16'h1234);
        collect(16'h0000, 16'h1234, 1, 0);
        send(16'hABCD, 16'h0000);
        collect(16'hABCD, 16'h0000, 1, 0);
    endtask

    task automatic test_no_skip();
        int n;
        @(negedge Clock);
        iA0 = 16'h0000; iB0 = 16'h1234; iValid0 = 1'b1;
        @(posedge Clock);
        sb.push_back(32'h0);
        #1 iValid0 = 1'b0;
        n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!oValid0 && n < 40);
        compared++;
        if (n != 17) begin
            mismatched++;
            $display("FAIL noskip_latency: oValid after %0d edges required 16", n - 1);
        end
        compared++;
        if (oP0 !== sb.pop_front()) begin
            mismatched++;
            $display("FAIL noskip_product: oP=%h required 00000000", oP0);
        end
        @(negedge Clock);
    endtask

    task automatic test_back_to_back();
        send(16'h0007, 16'h0009);
        iA = 16'h0011; iB = 16'h0002; iValid = 1'b1;
        collect(16'h0007, 16'h0009, 16, 5);
        @(posedge Clock);
        sb.push_back(32'h0000_0022);
        #1 iValid = 1'b0;
        collect(16'h0011, 16'h0002, 16, 0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] dropped;
        send(16'h1234, 16'hABCD);
        repeat (8) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        dropped = sb.pop_front();
        compared++;
        if (oValid !== 1'b0 || oReady !== 1'b1 || oP !== 32'h0 ||
            oMulA !== 4'h0 || oMulB !== 4'h0 || oBusy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid: V=%b R=%b P=%h A=%h B=%h busy=%b required 0 1 0 0 0 0 (dropped %h)",
                     oValid, oReady, oP, oMulA, oMulB, oBusy, dropped);
        end
        Reset = 1'b1;
        @(negedge Clock);
        send(16'h0002, 16'h0002);
        collect(16'h0002, 16'h0002, 16, 0);
    endtask

    initial begin
        test_reset();
        test_small();
        test_patterns();
        test_zero_bypass();
        test_no_skip();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
